// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage has priority; external bursts take idle
// DM cycles. A starvation counter forces an external beat after STARVE_LIMIT CPU wins.
module dm_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LEN_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [3:0]       c_be,
    input  logic [31:0]      c_addr,
    input  logic [31:0]      c_wdata,
    output logic             c_stall,
    output logic [31:0]      c_rdata,
    input  logic             e_start,
    input  logic             e_we,
    input  logic [31:0]      e_addr,
    input  logic [LEN_W-1:0] e_len,
    input  logic [31:0]      e_wdata,
    output logic             e_wready,
    output logic             e_rvalid,
    output logic [31:0]      e_rdata,
    output logic             e_busy,
    output logic             e_done,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_wdata,
    output logic             dm_we,
    input  logic [31:0]      dm_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q;
    logic             cmd_we_q;
    logic [31:0]      addr_q;
    logic [31:0]      addr_d;
    logic [LEN_W-1:0] cnt_q;
    logic [SW-1:0]    starve_q;
    logic             e_done_q;
    logic             e_rvalid_q;
    logic [31:0]      e_rdata_q;

    logic             starved;
    logic             ext_own;
    logic             c_gnt;
    logic [31:0]      cpu_merge;

    // Holding reset low masks both grants, so nothing reaches the DM during reset.
    assign starved = (starve_q == SW'(STARVE_LIMIT));
    assign ext_own = reset && (state_q == BURST) && (!c_req || starved);
    assign c_gnt   = reset && c_req && !ext_own;
    assign c_stall = c_req && !c_gnt;
    assign c_rdata = dm_rdata;

    // Only the word index advances, so bursts wrap inside the 4 KB window.
    assign addr_d  = {addr_q[31:12], addr_q[11:2] + 10'd1, 2'b00};

    always_comb begin
        cpu_merge = dm_rdata;
        for (int i = 0; i < 4; i++) begin
            if (c_be[i]) begin
                cpu_merge[8*i +: 8] = c_wdata[8*i +: 8];
            end
        end
    end

    assign dm_addr  = c_gnt ? c_addr : (ext_own ? addr_q : 32'h0);
    assign dm_wdata = c_gnt ? cpu_merge : (ext_own ? e_wdata : 32'h0);
    assign dm_we    = c_gnt ? (c_we && (c_be != 4'b0000)) : (ext_own && cmd_we_q);
    assign e_wready = ext_own && cmd_we_q;

    assign e_busy   = (state_q == BURST);
    assign e_done   = e_done_q;
    assign e_rvalid = e_rvalid_q;
    assign e_rdata  = e_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cmd_we_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            e_done_q   <= 1'b0;
            e_rvalid_q <= 1'b0;
            e_rdata_q  <= '0;
        end else begin
            e_done_q   <= 1'b0;
            e_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    starve_q <= '0;
                    if (e_start) begin
                        cmd_we_q <= e_we;
                        addr_q   <= {e_addr[31:2], 2'b00};
                        cnt_q    <= e_len;
                        state_q  <= BURST;
                    end
                end
                BURST: begin
                    if (ext_own) begin
                        starve_q <= '0;
                        addr_q   <= addr_d;
                        if (!cmd_we_q) begin
                            e_rvalid_q <= 1'b1;
                            e_rdata_q  <= dm_rdata;
                        end
                        if (cnt_q == '0) begin
                            state_q  <= IDLE;
                            e_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end else if (c_gnt && !starved) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level model of memory and burst progress.
module tb_dm_port_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int LEN_W        = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             c_req = 1'b0;
    logic             c_we = 1'b0;
    logic [3:0]       c_be = 4'b0;
    logic [31:0]      c_addr = 32'h0;
    logic [31:0]      c_wdata = 32'h0;
    logic             c_stall;
    logic [31:0]      c_rdata;
    logic             e_start = 1'b0;
    logic             e_we = 1'b0;
    logic [31:0]      e_addr = 32'h0;
    logic [LEN_W-1:0] e_len = '0;
    logic [31:0]      e_wdata = 32'h0;
    logic             e_wready;
    logic             e_rvalid;
    logic [31:0]      e_rdata;
    logic             e_busy;
    logic             e_done;
    logic [31:0]      dm_addr;
    logic [31:0]      dm_wdata;
    logic             dm_we;
    logic [31:0]      dm_rdata;

    dm_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_stall(c_stall), .c_rdata(c_rdata),
        .e_start(e_start), .e_we(e_we), .e_addr(e_addr), .e_len(e_len), .e_wdata(e_wdata),
        .e_wready(e_wready), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .e_busy(e_busy), .e_done(e_done),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Single-port data memory: combinational read, write on the rising edge.
    logic [31:0] mem [0:1023];
    assign dm_rdata = mem[dm_addr[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
        forever begin
            @(posedge clk);
            if (dm_we) mem[dm_addr[11:2]] <= dm_wdata;
        end
    end

    int compared = 0;
    int mismatched = 0;

    // Reference model: expected memory contents and burst progress in plain counts.
    logic [31:0] refMem [0:1023];
    int          burstLeft = 0;
    bit          bWe = 1'b0;
    logic [19:0] bUpper = '0;
    int          bIdx = 0;
    int          cpuWins = 0;
    bit          modelValid = 1'b0;
    bit          pendDone = 1'b0;
    bit          pendRvalid = 1'b0;
    logic [31:0] pendRdata = 32'h0;

    logic [31:0] obsStall, obsRdata, obsWe, obsAddr, obsWready, obsRvalid, obsDone, obsBusy;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit creq, input bit cwe,
                                 input logic [3:0] cbe, input logic [31:0] caddr,
                                 input logic [31:0] cwdata, input bit estart, input bit ewe,
                                 input logic [31:0] eaddr, input logic [3:0] elen,
                                 input logic [31:0] ewdata);
        bit          idleNow, extTurn, cpuGnt, expWe;
        logic [31:0] expAddr, expWdata, merged;
        int          cIdx;
        @(negedge clk);
        reset = rst; c_req = creq; c_we = cwe; c_be = cbe; c_addr = caddr; c_wdata = cwdata;
        e_start = estart; e_we = ewe; e_addr = eaddr; e_len = elen; e_wdata = ewdata;
        #1;
        obsStall = 32'(c_stall); obsRdata = c_rdata; obsWe = 32'(dm_we); obsAddr = dm_addr;
        obsWready = 32'(e_wready); obsRvalid = 32'(e_rvalid); obsDone = 32'(e_done);
        obsBusy = 32'(e_busy);

        if (modelValid) begin
            checkOutput("e_busy", obsBusy, 32'(burstLeft > 0));
            checkOutput("e_done", obsDone, 32'(pendDone));
            checkOutput("e_rvalid", obsRvalid, 32'(pendRvalid));
            checkOutput("e_rdata", e_rdata, pendRdata);
        end

        if (!rst) begin
            checkOutput("rst_c_stall", obsStall, 32'(creq));
            checkOutput("rst_dm_we", obsWe, 32'h0);
            checkOutput("rst_e_wready", obsWready, 32'h0);
            burstLeft = 0; cpuWins = 0; pendDone = 0; pendRvalid = 0; pendRdata = 32'h0;
            modelValid = 1'b1;
            return;
        end

        idleNow = (burstLeft == 0);
        extTurn = !idleNow && (!creq || cpuWins == STARVE_LIMIT);
        cpuGnt  = creq && !extTurn;
        cIdx    = int'(caddr[11:2]);
        for (int b = 0; b < 4; b++)
            merged[8*b +: 8] = cbe[b] ? cwdata[8*b +: 8] : refMem[cIdx][8*b +: 8];
        expAddr  = cpuGnt ? caddr : (extTurn ? {bUpper, bIdx[9:0], 2'b00} : 32'h0);
        expWe    = cpuGnt ? (cwe && cbe != 4'b0) : (extTurn && bWe);
        expWdata = cpuGnt ? merged : ewdata;

        checkOutput("c_stall", obsStall, 32'(creq && !cpuGnt));
        checkOutput("dm_we", obsWe, 32'(expWe));
        checkOutput("dm_addr", obsAddr, expAddr);
        checkOutput("e_wready", obsWready, 32'(extTurn && bWe));
        if (expWe) checkOutput("dm_wdata", dm_wdata, expWdata);
        if (cpuGnt && !cwe) checkOutput("c_rdata", obsRdata, refMem[cIdx]);

        pendDone = 1'b0;
        pendRvalid = 1'b0;
        if (cpuGnt && cwe) refMem[cIdx] = merged;
        if (extTurn) begin
            if (bWe) refMem[bIdx] = ewdata;
            else begin
                pendRvalid = 1'b1;
                pendRdata = refMem[bIdx];
            end
            bIdx = (bIdx + 1) % 1024;
            burstLeft--;
            cpuWins = 0;
            if (burstLeft == 0) pendDone = 1'b1;
        end else if (!idleNow && cpuGnt) begin
            cpuWins++;
        end
        if (idleNow) begin
            cpuWins = 0;
            if (estart) begin
                burstLeft = int'(elen) + 1;
                bWe = ewe;
                bUpper = eaddr[31:12];
                bIdx = int'(eaddr[11:2]);
            end
        end
    endtask

    task automatic nop();
        applyStimulus(1, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, $urandom);
    endtask

    task automatic cpuOp(input bit we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] data);
        applyStimulus(1, 1, we, be, addr, data, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic startBurst(input bit we, input logic [31:0] addr, input logic [3:0] len);
        applyStimulus(1, 0, 0, 4'b0, 32'h0, 32'h0, 1, we, addr, len, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0]  vec, vec2;
        logic [3:0]  beTab [0:7];
        logic [3:0]  be;
        logic [31:0] addrs [0:3];
        int          flush;

        beTab[0] = 4'b1111; beTab[1] = 4'b0011; beTab[2] = 4'b1100; beTab[3] = 4'b0001;
        beTab[4] = 4'b0010; beTab[5] = 4'b0100; beTab[6] = 4'b1000; beTab[7] = 4'b0000;
        for (int i = 0; i < 1024; i++) refMem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
        applyStimulus(0, 1, 0, 4'b0, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0);
        nop();
        checkOutput("reset_busy", obsBusy, 32'h0);
        checkOutput("reset_done", obsDone, 32'h0);
        checkOutput("reset_rvalid", obsRvalid, 32'h0);

        $display("[TB] CPU word store and load");
        cpuOp(1, 4'b1111, 32'h10, 32'h12345678);
        checkOutput("sw_stall", obsStall, 32'h0);
        checkOutput("sw_we", obsWe, 32'h1);
        cpuOp(0, 4'b1111, 32'h10, 32'h0);
        checkOutput("lw_stall", obsStall, 32'h0);
        checkOutput("lw_we", obsWe, 32'h0);
        checkOutput("lw_data", obsRdata, 32'h12345678);

        $display("[TB] byte store read-modify-write");
        cpuOp(1, 4'b1111, 32'h20, 32'hAABBCCDD);
        cpuOp(1, 4'b0010, 32'h20, 32'h00001100);
        cpuOp(0, 4'b1111, 32'h20, 32'h0);
        checkOutput("sb_merge", obsRdata, 32'hAABB11DD);
        cpuOp(1, 4'b0000, 32'h20, 32'hFFFFFFFF);
        checkOutput("be0_we", obsWe, 32'h0);

        $display("[TB] external write burst");
        startBurst(1, 32'h100, 4'd3);
        vec[0] = obsWready[0]; vec2[0] = obsDone[0];
        for (int k = 1; k < 6; k++) begin
            nop();
            vec[k] = obsWready[0]; vec2[k] = obsDone[0];
        end
        checkOutput("wr_wready_pattern", 32'(vec), 32'(6'b011110));
        checkOutput("wr_done_pattern", 32'(vec2), 32'(6'b100000));

        $display("[TB] external read burst with wrap");
        startBurst(0, 32'hFF8, 4'd3);
        vec[0] = obsRvalid[0];
        for (int k = 1; k < 6; k++) begin
            nop();
            vec[k] = obsRvalid[0];
            if (k <= 4) addrs[k-1] = obsAddr;
        end
        checkOutput("rd_addr0", addrs[0], 32'hFF8);
        checkOutput("rd_addr1", addrs[1], 32'hFFC);
        checkOutput("rd_addr2", addrs[2], 32'h000);
        checkOutput("rd_addr3", addrs[3], 32'h004);
        checkOutput("rd_rvalid_pattern", 32'(vec), 32'(6'b111100));

        $display("[TB] burst under continuous CPU traffic");
        applyStimulus(1, 1, 0, 4'b1111, 32'h40, 32'h0, 1, 1, 32'h300, 4'd7, 32'h0);
        checkOutput("accept_cpu_stall", obsStall, 32'h0);
        for (int k = 1; k <= 41; k++) begin
            be = beTab[$urandom_range(0, 7)];
            applyStimulus(1, 1, 1'($urandom_range(0, 1)), be, 32'h40 + 32'($urandom_range(0, 15)) * 4,
                          $urandom, 0, 0, 32'h0, 4'h0, $urandom);
            if (k <= 40) checkOutput("starve_stall", obsStall, 32'(k % 5 == 0));
            else checkOutput("starve_done", obsDone, 32'h1);
        end

        $display("[TB] reset in the middle of a burst");
        startBurst(1, 32'h180, 4'd7);
        nop();
        nop();
        applyStimulus(0, 1, 1, 4'b1111, 32'h44, 32'hDEADBEEF, 0, 0, 32'h0, 4'h0, 32'h0);
        checkOutput("midrst_we", obsWe, 32'h0);
        checkOutput("midrst_stall", obsStall, 32'h1);
        nop();
        checkOutput("midrst_busy", obsBusy, 32'h0);
        checkOutput("midrst_done", obsDone, 32'h0);
        for (int k = 0; k < 3; k++) begin
            nop();
            checkOutput("midrst_no_done", obsDone, 32'h0);
        end
        startBurst(1, 32'h200, 4'd1);
        nop();
        checkOutput("restart_wready1", obsWready, 32'h1);
        nop();
        checkOutput("restart_wready2", obsWready, 32'h1);
        nop();
        checkOutput("restart_done", obsDone, 32'h1);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            be = beTab[$urandom_range(0, 7)];
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1),
                          1'($urandom_range(0, 1)), be, 32'($urandom_range(0, 63)) * 4, $urandom,
                          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), $urandom,
                          4'($urandom_range(0, 15)), $urandom);
        end

        flush = 0;
        while (burstLeft > 0 && flush < 100) begin
            nop();
            flush++;
        end
        checkOutput("flush_bound", 32'(burstLeft), 32'h0);
        nop();
        for (int i = 0; i < 1024; i++) checkOutput("mem_word", mem[i], refMem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
